// File: rtl/beta_pkg.sv
// Shared encodings for the Beta control unit: opcodes, ALU function codes,
// datapath select enums and the decoded-control bundle.
package beta_pkg;

    // Memory / control-flow opcodes (instruction[31:26])
    localparam logic [5:0] OP_LD  = 6'b011000;
    localparam logic [5:0] OP_ST  = 6'b011001;
    localparam logic [5:0] OP_JMP = 6'b011011;
    localparam logic [5:0] OP_BEQ = 6'b011100;
    localparam logic [5:0] OP_BNE = 6'b011101;
    localparam logic [5:0] OP_LDR = 6'b011111;

    // ALU function codes
    localparam logic [5:0] ALUFN_NONE   = 6'b000000;
    localparam logic [5:0] ALUFN_ADD    = 6'b100000;
    localparam logic [5:0] ALUFN_PASS_A = 6'b011010;

    // Next-PC source select
    typedef enum logic [2:0] {
        PCSEL_INC   = 3'd0,
        PCSEL_BR    = 3'd1,
        PCSEL_JMP   = 3'd2,
        PCSEL_ILLOP = 3'd3,
        PCSEL_XADR  = 3'd4
    } pcsel_t;

    // Register-file write-data select
    typedef enum logic [1:0] {
        WDSEL_PC  = 2'd0,
        WDSEL_ALU = 2'd1,
        WDSEL_MEM = 2'd2
    } wdsel_t;

    // Conditional-branch flavour, resolved against z in the top level
    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_EQ   = 2'd1,
        BR_NE   = 2'd2
    } branch_t;

    // Everything the opcode table produces
    typedef struct packed {
        logic [5:0] alufn;
        logic       asel;
        logic       bsel;
        logic       moe;
        logic       mwr;
        pcsel_t     pcsel;
        logic       ra2sel;
        logic       wasel;
        wdsel_t     wdsel;
        logic       werf;
        branch_t    branch;
    } ctrl_t;

    // ALU sub-functions 0111 and 1111 have no ALU operation behind them
    function automatic logic alu_func_illegal(input logic [3:0] func);
        return (func == 4'b0111) || (func == 4'b1111);
    endfunction

    // Quiet bundle: no writes, no reads, sequential PC
    function automatic ctrl_t ctrl_default();
        ctrl_t c;
        c.alufn  = ALUFN_NONE;
        c.asel   = 1'b0;
        c.bsel   = 1'b0;
        c.moe    = 1'b0;
        c.mwr    = 1'b0;
        c.pcsel  = PCSEL_INC;
        c.ra2sel = 1'b0;
        c.wasel  = 1'b0;
        c.wdsel  = WDSEL_PC;
        c.werf   = 1'b0;
        c.branch = BR_NONE;
        return c;
    endfunction

    // Illegal-op trap: save PC+4 into XP and vector to ILLOP
    function automatic ctrl_t ctrl_illop();
        ctrl_t c;
        c       = ctrl_default();
        c.pcsel = PCSEL_ILLOP;
        c.wasel = 1'b1;
        c.wdsel = WDSEL_PC;
        c.werf  = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/beta_opcode_decode.sv
// Pure combinational opcode table for the Beta control unit. Branch
// direction, interrupts and reset gating are applied by the top level.
module beta_opcode_decode
    import beta_pkg::*;
(
    input  logic [5:0] opcode,
    output ctrl_t      ctrl
);

    // Opcode to control bundle lookup
    always_comb begin
        ctrl = ctrl_default();
        if (opcode[5] == 1'b1) begin
            // OP (10xxxx) and OPC (11xxxx) share the ALU path; OPC takes the literal
            if (alu_func_illegal(opcode[3:0])) begin
                ctrl = ctrl_illop();
            end else begin
                ctrl.alufn = {2'b10, opcode[3:0]};
                ctrl.bsel  = opcode[4];
                ctrl.wdsel = WDSEL_ALU;
                ctrl.werf  = 1'b1;
            end
        end else begin
            case (opcode)
                OP_LD: begin
                    ctrl.alufn = ALUFN_ADD;
                    ctrl.bsel  = 1'b1;
                    ctrl.moe   = 1'b1;
                    ctrl.wdsel = WDSEL_MEM;
                    ctrl.werf  = 1'b1;
                end
                OP_ST: begin
                    ctrl.alufn  = ALUFN_ADD;
                    ctrl.bsel   = 1'b1;
                    ctrl.ra2sel = 1'b1;
                    ctrl.mwr    = 1'b1;
                end
                OP_JMP: begin
                    ctrl.pcsel = PCSEL_JMP;
                    ctrl.wdsel = WDSEL_PC;
                    ctrl.werf  = 1'b1;
                end
                OP_BEQ: begin
                    ctrl.branch = BR_EQ;
                    ctrl.wdsel  = WDSEL_PC;
                    ctrl.werf   = 1'b1;
                end
                OP_BNE: begin
                    ctrl.branch = BR_NE;
                    ctrl.wdsel  = WDSEL_PC;
                    ctrl.werf   = 1'b1;
                end
                OP_LDR: begin
                    ctrl.alufn = ALUFN_PASS_A;
                    ctrl.asel  = 1'b1;
                    ctrl.moe   = 1'b1;
                    ctrl.wdsel = WDSEL_MEM;
                    ctrl.werf  = 1'b1;
                end
                default: begin
                    ctrl = ctrl_illop();
                end
            endcase
        end
    end

endmodule

// File: rtl/beta_control_unit.sv
// Beta control unit: opcode decode plus branch resolution, interrupt
// pending/service override and reset gating of the state-changing strobes.
module beta_control_unit
    import beta_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instruction,
    input  logic        z,
    input  logic        irq,
    input  logic        supervisor,
    output logic [5:0]  ALUFN,
    output logic        ASEL,
    output logic        BSEL,
    output logic        MOE,
    output logic        MWR,
    output logic [2:0]  PCSEL,
    output logic        RA2SEL,
    output logic        WASEL,
    output logic [1:0]  WDSEL,
    output logic        WERF
);

    ctrl_t  dec_s;
    pcsel_t pcsel_br_s;
    logic   irq_pending_r;
    logic   service_s;
    logic   unused_s;

    // Only the opcode field steers control
    assign unused_s = ^instruction[25:0];

    beta_opcode_decode u_decode (
        .opcode (instruction[31:26]),
        .ctrl   (dec_s)
    );

    // Interrupts are taken only from user mode
    always_comb begin
        service_s = irq_pending_r & ~supervisor;
    end

    // Pending flag: a new request wins over the clear on a serviced edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_pending_r <= 1'b0;
        end else begin
            irq_pending_r <= irq | (irq_pending_r & ~service_s);
        end
    end

    // Resolve conditional branches against the register-zero test
    always_comb begin
        pcsel_br_s = dec_s.pcsel;
        case (dec_s.branch)
            BR_EQ:   pcsel_br_s = z ? PCSEL_BR : PCSEL_INC;
            BR_NE:   pcsel_br_s = z ? PCSEL_INC : PCSEL_BR;
            default: pcsel_br_s = dec_s.pcsel;
        endcase
    end

    // Output mux: decode, then interrupt override, then reset gating
    always_comb begin
        ALUFN  = dec_s.alufn;
        ASEL   = dec_s.asel;
        BSEL   = dec_s.bsel;
        MOE    = dec_s.moe;
        MWR    = dec_s.mwr;
        PCSEL  = pcsel_br_s;
        RA2SEL = dec_s.ra2sel;
        WASEL  = dec_s.wasel;
        WDSEL  = dec_s.wdsel;
        WERF   = dec_s.werf;

        if (service_s) begin
            PCSEL = PCSEL_XADR;
            WASEL = 1'b1;
            WDSEL = WDSEL_PC;
            WERF  = 1'b1;
            MWR   = 1'b0;
            MOE   = 1'b0;
        end else begin
            PCSEL = PCSEL;
        end

        if (!reset_n) begin
            MWR   = 1'b0;
            WERF  = 1'b0;
            MOE   = 1'b0;
            PCSEL = PCSEL_INC;
        end else begin
            WERF  = WERF;
        end
    end

endmodule

// File: tb/tb_beta_control_unit.sv
// Directed self-checking bench for beta_control_unit.
module tb_beta_control_unit;

    logic        clk;
    logic        reset_n;
    logic [31:0] instruction;
    logic        z;
    logic        irq;
    logic        supervisor;
    logic [5:0]  ALUFN;
    logic        ASEL;
    logic        BSEL;
    logic        MOE;
    logic        MWR;
    logic [2:0]  PCSEL;
    logic        RA2SEL;
    logic        WASEL;
    logic [1:0]  WDSEL;
    logic        WERF;

    int compared   = 0;
    int mismatched = 0;

    logic [17:0] obs;
    logic [17:0] st_norm;
    logic [17:0] st_srv;
    logic [17:0] st_rst;

    beta_control_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .instruction (instruction),
        .z           (z),
        .irq         (irq),
        .supervisor  (supervisor),
        .ALUFN       (ALUFN),
        .ASEL        (ASEL),
        .BSEL        (BSEL),
        .MOE         (MOE),
        .MWR         (MWR),
        .PCSEL       (PCSEL),
        .RA2SEL      (RA2SEL),
        .WASEL       (WASEL),
        .WDSEL       (WDSEL),
        .WERF        (WERF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {ALUFN, ASEL, BSEL, MOE, MWR, PCSEL, RA2SEL, WASEL, WDSEL, WERF};

    function automatic logic [17:0] v(input logic [5:0] alufn, input logic asel,
                                      input logic bsel, input logic moe, input logic mwr,
                                      input logic [2:0] pcsel, input logic ra2sel,
                                      input logic wasel, input logic [1:0] wdsel,
                                      input logic werf);
        return {alufn, asel, bsel, moe, mwr, pcsel, ra2sel, wasel, wdsel, werf};
    endfunction

    task automatic chk(input string tag, input logic [17:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic op(input logic [5:0] opc);
        instruction = {opc, 26'h155_1234};
        #2;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        st_norm = v(6'b100000, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 2'd0, 1'b0);
        st_srv  = v(6'b100000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 2'd0, 1'b1);
        st_rst  = v(6'b100000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 2'd0, 1'b0);

        reset_n = 1'b0; z = 1'b0; irq = 1'b0; supervisor = 1'b0;
        op(6'b100000);
        chk("reset_op_add", v(6'b100000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd1, 1'b0));
        edge1();
        edge1();
        reset_n = 1'b1;
        op(6'b100000);
        chk("op_add", v(6'b100000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd1, 1'b1));
        op(6'b110000);
        chk("opc_add", v(6'b100000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd1, 1'b1));
        op(6'b100001);
        chk("op_sub", v(6'b100001, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd1, 1'b1));
        op(6'b111010);
        chk("opc_1010", v(6'b101010, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd1, 1'b1));
        op(6'b100111);
        chk("op_0111_illegal", v(6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 2'd0, 1'b1));
        op(6'b111111);
        chk("opc_1111_illegal", v(6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 2'd0, 1'b1));
        op(6'b011000);
        chk("ld", v(6'b100000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 2'd2, 1'b1));
        op(6'b011001);
        chk("st", st_norm);
        op(6'b011011);
        chk("jmp", v(6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 2'd0, 1'b1));
        z = 1'b1; op(6'b011100);
        chk("beq_z1", v(6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 2'd0, 1'b1));
        z = 1'b0; op(6'b011100);
        chk("beq_z0", v(6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1));
        z = 1'b1; op(6'b011101);
        chk("bne_z1", v(6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1));
        z = 1'b0; op(6'b011101);
        chk("bne_z0", v(6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 2'd0, 1'b1));
        op(6'b011111);
        chk("ldr", v(6'b011010, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 2'd2, 1'b1));
        op(6'b000000);
        chk("illegal_000000", v(6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 2'd0, 1'b1));
        op(6'b011010);
        chk("illegal_011010", v(6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 2'd0, 1'b1));

        // Interrupt in user mode: service one cycle after the pulse, then normal
        op(6'b011001);
        irq = 1'b1;
        chk("irq_same_cycle", st_norm);
        edge1();
        irq = 1'b0;
        #1;
        chk("irq_service", st_srv);
        edge1();
        chk("irq_after_service", st_norm);

        // Interrupt service beats the illegal-op trap
        irq = 1'b1;
        edge1();
        irq = 1'b0;
        op(6'b000000);
        chk("irq_over_illop", v(6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 2'd0, 1'b1));
        edge1();
        op(6'b011001);

        // Supervisor mode masks: request stays pending until user mode
        supervisor = 1'b1;
        irq = 1'b1;
        edge1();
        irq = 1'b0;
        #1;
        chk("sup_masked", st_norm);
        edge1();
        edge1();
        chk("sup_still_masked", st_norm);
        supervisor = 1'b0;
        #1;
        chk("sup_pending_taken", st_srv);
        edge1();
        chk("sup_cleared", st_norm);

        // Held request: set wins over clear, so service repeats
        irq = 1'b1;
        edge1();
        chk("held_service1", st_srv);
        edge1();
        chk("held_service2", st_srv);
        irq = 1'b0;
        edge1();
        chk("held_released", st_norm);

        // Asynchronous reset while pending
        supervisor = 1'b1;
        irq = 1'b1;
        edge1();
        irq = 1'b0;
        #2;
        reset_n = 1'b0;
        op(6'b100000);
        chk("rst_mid_op", v(6'b100000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd1, 1'b0));
        op(6'b011001);
        chk("rst_mid_st", st_rst);
        reset_n = 1'b1;
        supervisor = 1'b0;
        #1;
        chk("rst_cleared_pending", st_norm);
        edge1();
        chk("rst_cleared_next", st_norm);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
